// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the writeback path.
package regfile_pkg;

    localparam int DW   = 16;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t dest;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered
// pointer that advances past the winner on every grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N-1:0]                          valid,
    output logic [N-1:0]                          grant,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]    grant_idx,
    output logic                                  any_grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_grant && valid[(int'(ptr_reg) + k) % N]) begin
                grant[(int'(ptr_reg) + k) % N] = 1'b1;
                grant_idx = PW'((int'(ptr_reg) + k) % N);
                any_grant = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (any_grant) begin
            ptr_next = PW'((int'(grant_idx) + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ requesters and tracks pending
// destinations in a busy scoreboard. WB_BYPASS_EN adds commit-cycle forwarding.
module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = regfile_pkg::DW,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_dest,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               reg_wrt,
    output logic [AW-1:0]      wr_dest,
    output logic [DW-1:0]      wr_data,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_dest,
    output logic               iss_ready,
    input  logic [AW-1:0]      rd_a,
    input  logic [AW-1:0]      rd_b,
`ifdef WB_BYPASS_EN
    output logic               fwd_a_hit,
    output logic               fwd_b_hit,
    output logic [DW-1:0]      fwd_a_data,
    output logic [DW-1:0]      fwd_b_data,
`endif
    output logic               busy_a,
    output logic               busy_b
);
    import regfile_pkg::*;

    localparam int NR = 2 ** AW;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] grant_idx;
    logic          xfer;
    logic [AW-1:0] sel_dest;
    logic [DW-1:0] sel_data;
    logic          sel_live;

    logic [NR-1:0] busy_reg;
    logic [NR-1:0] busy_eff;
    logic [NR-1:0] busy_next;

    logic          reg_wrt_reg;
    logic [AW-1:0] wr_dest_reg;
    logic [DW-1:0] wr_data_reg;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .any_grant (xfer)
    );

    assign sel_dest = req_dest[int'(grant_idx)*AW +: AW];
    assign sel_data = req_data[int'(grant_idx)*DW +: DW];
    assign sel_live = xfer && (sel_dest != '0);

    // The clear is visible combinationally so lookups see it in the transfer cycle.
    always_comb begin
        busy_eff = busy_reg;
        if (sel_live) begin
            busy_eff[sel_dest] = 1'b0;
        end
    end

    assign iss_ready = ~busy_eff[iss_dest];
    assign busy_a    = busy_eff[rd_a];
    assign busy_b    = busy_eff[rd_b];

    // Claiming after the clear lets a same-cycle set win.
    always_comb begin
        busy_next = busy_eff;
        if (iss_valid && iss_ready && (iss_dest != '0)) begin
            busy_next[iss_dest] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg    <= '0;
            reg_wrt_reg <= 1'b0;
            wr_dest_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            busy_reg    <= busy_next;
            reg_wrt_reg <= sel_live;
            if (sel_live) begin
                wr_dest_reg <= sel_dest;
                wr_data_reg <= sel_data;
            end
        end
    end

    assign reg_wrt = reg_wrt_reg;
    assign wr_dest = wr_dest_reg;
    assign wr_data = wr_data_reg;

`ifdef WB_BYPASS_EN
    assign fwd_a_hit  = reg_wrt_reg && (wr_dest_reg == rd_a) && (rd_a != '0);
    assign fwd_b_hit  = reg_wrt_reg && (wr_dest_reg == rd_b) && (rd_b != '0);
    assign fwd_a_data = wr_data_reg;
    assign fwd_b_data = wr_data_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write port, scoreboard, reset.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 16;
    localparam int AW   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_dest;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               reg_wrt;
    logic [AW-1:0]      wr_dest;
    logic [DW-1:0]      wr_data;
    logic               iss_valid;
    logic [AW-1:0]      iss_dest;
    logic               iss_ready;
    logic [AW-1:0]      rd_a;
    logic [AW-1:0]      rd_b;
    logic               busy_a;
    logic               busy_b;
`ifdef WB_BYPASS_EN
    logic               fwd_a_hit;
    logic               fwd_b_hit;
    logic [DW-1:0]      fwd_a_data;
    logic [DW-1:0]      fwd_b_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_wrt    (reg_wrt),
        .wr_dest    (wr_dest),
        .wr_data    (wr_data),
        .iss_valid  (iss_valid),
        .iss_dest   (iss_dest),
        .iss_ready  (iss_ready),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
`ifdef WB_BYPASS_EN
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data),
`endif
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [AW-1:0] d0, input logic [DW-1:0] x0,
                           input logic [AW-1:0] d1, input logic [DW-1:0] x1);
        req_valid = v;
        req_dest  = {d1, d0};
        req_data  = {x1, x0};
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_dest = '0; req_data = '0;
        iss_valid = 1'b0; iss_dest = 5'd5; rd_a = 5'd5; rd_b = 5'd0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_reg_wrt", 32'(reg_wrt), 32'd0);
        chk("rst_wr_dest", 32'(wr_dest), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);

        // Single write from requester 0.
        set_req(2'b01, 5'd3, 16'h00AA, 5'd0, 16'h0);
        chk("single_ready", 32'(req_ready), 32'b01);
        step();
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        chk("single_wrt", 32'(reg_wrt), 32'd1);
        chk("single_dest", 32'(wr_dest), 32'd3);
        chk("single_data", 32'(wr_data), 32'h00AA);
        step();
        chk("idle_wrt", 32'(reg_wrt), 32'd0);
        chk("idle_dest_hold", 32'(wr_dest), 32'd3);

        // Contention from a fresh pointer: grants alternate starting with req0.
        rst = 1'b1; step(); rst = 1'b0;
        set_req(2'b11, 5'd1, 16'h1111, 5'd2, 16'h2222);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_ready_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            step();
            chk($sformatf("rr_wrt_%0d", k), 32'(reg_wrt), 32'd1);
            chk($sformatf("rr_dest_%0d", k), 32'(wr_dest), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);

        // RAW on register 5.
        iss_valid = 1'b1; iss_dest = 5'd5; rd_a = 5'd5; #1;
        chk("raw_claim_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0; #1;
        chk("raw_busy_a", 32'(busy_a), 32'd1);
        chk("waw_iss_ready", 32'(iss_ready), 32'd0);
        set_req(2'b10, 5'd0, 16'h0, 5'd5, 16'h0555);
        chk("raw_wb_ready", 32'(req_ready), 32'b10);
        chk("raw_busy_xfer", 32'(busy_a), 32'd0);
        chk("raw_iss_xfer", 32'(iss_ready), 32'd1);
        step();
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        chk("raw_wb_dest", 32'(wr_dest), 32'd5);
        chk("raw_busy_after", 32'(busy_a), 32'd0);

        // Same-cycle clear and set of register 7: set wins.
        iss_valid = 1'b1; iss_dest = 5'd7; rd_b = 5'd7;
        step();
        set_req(2'b01, 5'd7, 16'h0777, 5'd0, 16'h0);
        chk("sc_iss_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        chk("sc_busy7", 32'(busy_b), 32'd1);
        chk("sc_wr_dest", 32'(wr_dest), 32'd7);

        // Writeback to register 0 is swallowed.
        rd_a = 5'd0;
        set_req(2'b10, 5'd0, 16'h0, 5'd0, 16'hFFFF);
        chk("r0_ready", 32'(req_ready), 32'b10);
        step();
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        chk("r0_wrt", 32'(reg_wrt), 32'd0);
        chk("r0_busy7", 32'(busy_b), 32'd1);
        chk("r0_busy_a0", 32'(busy_a), 32'd0);

        // Move the pointer to req1, then reset during a grant.
        set_req(2'b01, 5'd1, 16'h0101, 5'd0, 16'h0);
        step();
        set_req(2'b11, 5'd1, 16'h0101, 5'd2, 16'h0202);
        chk("prerst_ready", 32'(req_ready), 32'b10);
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("midrst_wrt", 32'(reg_wrt), 32'd0);
        chk("midrst_busy7", 32'(busy_b), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'b01);
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);

`ifdef WB_BYPASS_EN
        rd_b = 5'd4;
        set_req(2'b01, 5'd4, 16'h1234, 5'd0, 16'h0);
        step();
        set_req(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        chk("fwd_b_hit", 32'(fwd_b_hit), 32'd1);
        chk("fwd_b_data", 32'(fwd_b_data), 32'h1234);
        rd_b = 5'd0; #1;
        chk("fwd_b_hit_r0", 32'(fwd_b_hit), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
